mips_mc_control: RTL and testbench
==================================

// Module: mips_mc_control
// PURPOSE
//  Multicycle main controller for the MIPS core. Sits directly upstream of the ALU.
//  Decodes opcode/funct, steps a Moore FSM and drives the ALU's aluControl and operand selects.
//  Also drives the PC, memory, IR and register-file enables for the shared datapath.
//  The ALU registers its result and zero flag on posedge clk, so every ALU-op state is followed by a consuming state.
// PARAMETERS
//  STATE_W   4          state register width; must be >= 4
//  OP_ADDI   6'b001000  opcode decoded as addi (used only with CTRL_ADDI_EN)
// PORTS
//  clk          in   1  single system clock, all flops on posedge
//  reset        in   1  asynchronous, active-high; forces state FETCH
//  opcode       in   6  instr[31:26] from IR
//  funct        in   6  instr[5:0] from IR
//  zero         in   1  registered ALU zero flag
//  pcWrite      out  1  load PC from pcSrc mux
//  pcSrc        out  2  00 aluOut, 10 jump target {PC[31:28],instr[25:0],2'b00}
//  iorD         out  1  memory address: 0 PC, 1 aluOut
//  memRead      out  1  memory read strobe
//  memWrite     out  1  memory write strobe
//  irWrite      out  1  latch IR from memory data
//  regDst       out  1  write register: 0 rt, 1 rd
//  memToReg     out  1  write data: 0 aluOut, 1 MDR
//  regWrite     out  1  register-file write enable
//  aluSrcA      out  1  ALU a: 0 PC, 1 reg A
//  aluSrcB      out  2  ALU b: 00 reg B, 01 const 4, 10 sext(imm), 11 sext(imm)<<2
//  aluControl   out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
//  illegalOp    out  1  one-cycle pulse on an undecodable instruction
// BEHAVIOUR
//  - Moore outputs decode from state only; any output not listed for a state is 0. While reset is high, all outputs are 0.
//  - After reset release the first state is FETCH. The taken flop clears to 0.
//  - FETCH: memRead, irWrite, srcA=0, srcB=01, ADD. Next: DECODE.
//  - DECODE: pcWrite, pcSrc=00 (PC+4 now in aluOut). Dispatch on opcode:
//    100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 000010 -> JEX; anything else -> ILLEGAL.
//  - MEMADR: srcA=1, srcB=10, ADD. Next: MEMRD if lw, else MEMWR.
//  - MEMRD: iorD, memRead -> MEMWB. MEMWB: regWrite, memToReg=1, regDst=0 -> FETCH.
//  - MEMWR: iorD, memWrite -> FETCH.
//  - RTYPEEX: srcA=1, srcB=00, aluControl from funct -> RTYPEWB.
//    funct map: 100000 add 010, 100010 sub 110, 100100 and 000, 100101 or 001, 101010 slt 111.
//    Unknown funct: aluControl=010, illegalOp pulses in RTYPEEX, and RTYPEWB holds regWrite=0.
//  - RTYPEWB: regWrite, regDst=1, memToReg=0 -> FETCH.
//  - BEQEX: srcA=1, srcB=00, SUB -> BEQTGT.
//  - BEQTGT: srcA=0, srcB=11, ADD; taken <= zero at end of cycle -> BEQWB.
//  - BEQWB: pcWrite = taken, pcSrc=00 -> FETCH. taken is captured in BEQTGT because zero is overwritten at the BEQTGT edge.
//  - JEX: pcWrite, pcSrc=10 -> FETCH.
//  - ILLEGAL: illegalOp=1 for exactly one cycle, no writes -> FETCH.
//  - Cycle counts, FETCH to next FETCH: lw 5, sw 4, R-type 4, beq 5, j 3, addi 4, illegal 3.
//  - Unused state encodings -> FETCH on the next edge with all outputs 0.
//  - Reset asserted in any state (e.g. mid-MEMWR): all strobes drop immediately, with no partial write after release.
//  - opcode/funct are sampled only in DECODE and RTYPEEX. The IR is stable there because irWrite is high only in FETCH.
// CONFIGURATION
//  CTRL_ADDI_EN defined: opcode OP_ADDI in DECODE -> ADDIEX (srcA=1, srcB=10, ADD) -> ADDIWB (regWrite, regDst=0, memToReg=0) -> FETCH.
//  CTRL_ADDI_EN undefined: OP_ADDI is treated like any other unknown opcode and goes to ILLEGAL.
// TESTING
//  - reset high for 3 cycles mid-run, then release -> outputs all 0 during reset; first cycle after release memRead=irWrite=1, aluControl=010.
//  - lw (op 100011) -> memRead,irWrite / pcWrite / ADD srcB=10 / iorD,memRead / regWrite,memToReg=1; back in FETCH on cycle 6.
//  - R-type funct 100010, then 101010, then 111111 -> aluControl 110 then 111; the third gives an illegalOp pulse with regWrite=0 in WB.
//  - beq with zero=1 after BEQEX and zero=0 during BEQWB -> pcWrite=1 in BEQWB; repeat with zero=0 after BEQEX -> pcWrite=0.
//  - opcode 001000 -> with CTRL_ADDI_EN, regWrite=1, regDst=0 in cycle 4; without it, illegalOp=1 in cycle 3 and no regWrite.

Source files
------------

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle main controller for the MIPS core.
// Two-process Moore FSM that sequences the shared datapath (PC, memory, IR,
// register file) and drives the ALU operand selects and aluControl.
// Optional feature: define CTRL_ADDI_EN to decode OP_ADDI as addi
// (ADDIEX -> ADDIWB); otherwise OP_ADDI goes to ILLEGAL like any unknown opcode.

module mips_mc_control #(
   parameter int unsigned STATE_W = 4,
   parameter logic [5:0]  OP_ADDI = 6'b001000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcWrite,
   output logic [1:0] pcSrc,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       irWrite,
   output logic       regDst,
   output logic       memToReg,
   output logic       regWrite,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [2:0] aluControl,
   output logic       illegalOp
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BR   = 2'b11;

   localparam logic [1:0] PCSRC_ALUOUT = 2'b00;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Fifteen states need four bits; a narrower register cannot hold them.
   if (STATE_W < 4) begin : g_state_w_check
      $error("mips_mc_control: STATE_W must be >= 4");
   end

   typedef enum logic [STATE_W-1:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_RTYPEEX,
      S_RTYPEWB,
      S_BEQEX,
      S_BEQTGT,
      S_BEQWB,
      S_JEX,
      S_ILLEGAL,
      S_ADDIEX,
      S_ADDIWB
   } state_t;

   state_t     state;
   state_t     state_next;
   logic       taken;       // branch outcome captured from zero in BEQTGT
   logic       is_load;     // lw vs sw, captured in DECODE for MEMADR
   logic       bad_funct;   // unknown funct seen in RTYPEEX, blocks the WB write
   logic       funct_ok;
   logic [2:0] rtype_alu;

   // R-type funct to ALU operation; unknown functs fall back to add
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
      funct_ok  = 1'b1;
      rtype_alu = ALU_ADD;
      case (funct)
         6'b100000: rtype_alu = ALU_ADD;
         6'b100010: rtype_alu = ALU_SUB;
         6'b100100: rtype_alu = ALU_AND;
         6'b100101: rtype_alu = ALU_OR;
         6'b101010: rtype_alu = ALU_SLT;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // State register plus the small side flops that carry decode results forward
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_FETCH;
         taken     <= 1'b0;
         is_load   <= 1'b0;
         bad_funct <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
         state <= state_next;
         if (state == S_BEQTGT)  taken     <= zero;
         if (state == S_DECODE)  is_load   <= (opcode == OP_LW);
         if (state == S_RTYPEEX) bad_funct <= ~funct_ok;
      end
   end

   // Next-state logic; opcode is only looked at in DECODE
   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_RTYPEEX;
               OP_BEQ:       state_next = S_BEQEX;
               OP_J:         state_next = S_JEX;
`ifdef CTRL_ADDI_EN
               OP_ADDI:      state_next = S_ADDIEX;
`else
               OP_ADDI:      state_next = S_ILLEGAL;
`endif
               default:      state_next = S_ILLEGAL;
            endcase
         end
         S_MEMADR:  state_next = is_load ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_next = S_MEMWB;
         S_RTYPEEX: state_next = S_RTYPEWB;
         S_BEQEX:   state_next = S_BEQTGT;
         S_BEQTGT:  state_next = S_BEQWB;
`ifdef CTRL_ADDI_EN
         S_ADDIEX:  state_next = S_ADDIWB;
`endif
         default:   state_next = S_FETCH;
      endcase
   end

   // Moore output decode; everything not named for a state stays 0
   always_comb begin
      pcWrite    = 1'b0;
      pcSrc      = PCSRC_ALUOUT;
      iorD       = 1'b0;
      memRead    = 1'b0;
      memWrite   = 1'b0;
      irWrite    = 1'b0;
      regDst     = 1'b0;
      memToReg   = 1'b0;
      regWrite   = 1'b0;
      aluSrcA    = 1'b0;
      aluSrcB    = SRCB_REG;
      aluControl = ALU_AND;
      illegalOp  = 1'b0;
      // NOTE: outputs are gated by reset itself, not just by the FETCH reset state, so strobes drop the instant reset rises.
      if (!reset) begin
         case (state)
            S_FETCH: begin
               memRead    = 1'b1;
               irWrite    = 1'b1;
               aluSrcB    = SRCB_FOUR;
               aluControl = ALU_ADD;
            end
            S_DECODE: begin
               pcWrite = 1'b1;
               pcSrc   = PCSRC_ALUOUT;
            end
            S_MEMADR: begin
               aluSrcA    = 1'b1;
               aluSrcB    = SRCB_IMM;
               aluControl = ALU_ADD;
            end
            S_MEMRD: begin
               iorD    = 1'b1;
               memRead = 1'b1;
            end
            S_MEMWB: begin
               regWrite = 1'b1;
               memToReg = 1'b1;
            end
            S_MEMWR: begin
               iorD     = 1'b1;
               memWrite = 1'b1;
            end
            S_RTYPEEX: begin
               aluSrcA    = 1'b1;
               aluSrcB    = SRCB_REG;
               aluControl = rtype_alu;
               illegalOp  = ~funct_ok;
            end
            S_RTYPEWB: begin
               regWrite = ~bad_funct;
               regDst   = 1'b1;
            end
            S_BEQEX: begin
               aluSrcA    = 1'b1;
               aluSrcB    = SRCB_REG;
               aluControl = ALU_SUB;
            end
            S_BEQTGT: begin
               aluSrcB    = SRCB_BR;
               aluControl = ALU_ADD;
            end
            S_BEQWB: begin
               pcWrite = taken;
               pcSrc   = PCSRC_ALUOUT;
            end
            S_JEX: begin
               pcWrite = 1'b1;
               pcSrc   = PCSRC_JUMP;
            end
            S_ILLEGAL: illegalOp = 1'b1;
`ifdef CTRL_ADDI_EN
            S_ADDIEX: begin
               aluSrcA    = 1'b1;
               aluSrcB    = SRCB_IMM;
               aluControl = ALU_ADD;
            end
            S_ADDIWB: regWrite = 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: self-checking bench for mips_mc_control.
// The reference model turns each instruction (opcode, funct, branch outcome)
// into the list of control words expected on every cycle from FETCH to the
// next FETCH. Inputs change and outputs are compared just after the falling edge.

module tb_mips_mc_control;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;

   logic       pcWrite, iorD, memRead, memWrite, irWrite;
   logic       regDst, memToReg, regWrite, aluSrcA, illegalOp;
   logic [1:0] pcSrc, aluSrcB;
   logic [2:0] aluControl;

   typedef struct packed {
      logic       pcWrite;
      logic [1:0] pcSrc;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       regDst;
      logic       memToReg;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [2:0] aluControl;
      logic       illegalOp;
   } ctl_t;

   ctl_t act;
   assign act = {pcWrite, pcSrc, iorD, memRead, memWrite, irWrite, regDst,
                 memToReg, regWrite, aluSrcA, aluSrcB, aluControl, illegalOp};

   ctl_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   mips_mc_control dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .pcWrite    (pcWrite),
      .pcSrc      (pcSrc),
      .iorD       (iorD),
      .memRead    (memRead),
      .memWrite   (memWrite),
      .irWrite    (irWrite),
      .regDst     (regDst),
      .memToReg   (memToReg),
      .regWrite   (regWrite),
      .aluSrcA    (aluSrcA),
      .aluSrcB    (aluSrcB),
      .aluControl (aluControl),
      .illegalOp  (illegalOp)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic ctl_t fetch_word();
      ctl_t c = '0;
      c.memRead = 1'b1; c.irWrite = 1'b1; c.aluSrcB = 2'b01; c.aluControl = 3'b010;
      return c;
   endfunction

   // Build the per-cycle expected control words for one instruction.
   // zt is the zero flag presented during the cycle after BEQEX (index 3).
   function automatic void build_seq(input logic [5:0] op, input logic [5:0] fn, input logic zt);
      ctl_t c;
      logic [2:0] alu;
      logic known;
      exp_q.delete();
      exp_q.push_back(fetch_word());
      c = '0; c.pcWrite = 1'b1; exp_q.push_back(c);
      case (op)
         6'b100011, 6'b101011: begin
            c = '0; c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluControl = 3'b010; exp_q.push_back(c);
            if (op == 6'b100011) begin
               c = '0; c.iorD = 1'b1; c.memRead = 1'b1; exp_q.push_back(c);
               c = '0; c.regWrite = 1'b1; c.memToReg = 1'b1; exp_q.push_back(c);
            end else begin
               c = '0; c.iorD = 1'b1; c.memWrite = 1'b1; exp_q.push_back(c);
            end
         end
         6'b000000: begin
            known = 1'b1;
            case (fn)
               6'b100000: alu = 3'b010;
               6'b100010: alu = 3'b110;
               6'b100100: alu = 3'b000;
               6'b100101: alu = 3'b001;
               6'b101010: alu = 3'b111;
               default: begin alu = 3'b010; known = 1'b0; end
            endcase
            c = '0; c.aluSrcA = 1'b1; c.aluControl = alu; c.illegalOp = ~known; exp_q.push_back(c);
            c = '0; c.regWrite = known; c.regDst = 1'b1; exp_q.push_back(c);
         end
         6'b000100: begin
            c = '0; c.aluSrcA = 1'b1; c.aluControl = 3'b110; exp_q.push_back(c);
            c = '0; c.aluSrcB = 2'b11; c.aluControl = 3'b010; exp_q.push_back(c);
            c = '0; c.pcWrite = zt; exp_q.push_back(c);
         end
         6'b000010: begin
            c = '0; c.pcWrite = 1'b1; c.pcSrc = 2'b10; exp_q.push_back(c);
         end
`ifdef CTRL_ADDI_EN
         6'b001000: begin
            c = '0; c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluControl = 3'b010; exp_q.push_back(c);
            c = '0; c.regWrite = 1'b1; exp_q.push_back(c);
         end
`endif
         default: begin
            c = '0; c.illegalOp = 1'b1; exp_q.push_back(c);
         end
      endcase
   endfunction

   function automatic logic [5:0] rand_funct();
      logic [5:0] known [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      if ($urandom_range(0, 1) == 0) return known[$urandom_range(0, 4)];
      return 6'($urandom);
   endfunction

   function automatic logic [5:0] rand_opcode();
      case ($urandom_range(0, 6))
         0: return 6'b100011;
         1: return 6'b101011;
         2: return 6'b000000;
         3: return 6'b000100;
         4: return 6'b000010;
         5: return 6'b001000;
         default: return 6'($urandom);
      endcase
   endfunction

   // Apply inputs for cycle i of an instruction and settle. Zero carries the
   // branch outcome at index 3, its inverse at index 4, random noise elsewhere.
   task automatic drive(input int i, input logic [5:0] op, input logic [5:0] fn, input logic zt);
      opcode = op;
      funct  = fn;
      if (i == 3)      zero = zt;
      else if (i == 4) zero = ~zt;
      else             zero = 1'($urandom);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk); #1;
         n_checks++;
         if (act !== '0) begin
            n_fail++;
            $display("FAIL reset_hold got %h expected %h", act, ctl_t'('0));
         end
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (act !== fetch_word()) begin
         n_fail++;
         $display("FAIL reset_release_fetch got %h expected %h", act, fetch_word());
      end
   endtask

   task automatic test_lw_sw();
      logic [5:0] ops [2] = '{6'b100011, 6'b101011};
      foreach (ops[k]) begin
         logic [5:0] fn = 6'($urandom);
         logic zt = 1'($urandom);
         build_seq(ops[k], fn, zt);
         foreach (exp_q[i]) begin
            drive(i, ops[k], fn, zt);
            n_checks++;
            if (act !== exp_q[i]) begin
               n_fail++;
               $display("FAIL memop op=%b cyc%0d got %h expected %h", ops[k], i, act, exp_q[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_rtype();
      logic [5:0] fns [6] = '{6'b100010, 6'b101010, 6'b111111, 6'b100000, 6'b100100, 6'b100101};
      foreach (fns[k]) begin
         build_seq(6'b000000, fns[k], 1'b0);
         foreach (exp_q[i]) begin
            drive(i, 6'b000000, fns[k], 1'b0);
            n_checks++;
            if (act !== exp_q[i]) begin
               n_fail++;
               $display("FAIL rtype funct=%b cyc%0d got %h expected %h", fns[k], i, act, exp_q[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_beq();
      logic zts [2] = '{1'b1, 1'b0};
      foreach (zts[k]) begin
         logic [5:0] fn = 6'($urandom);
         build_seq(6'b000100, fn, zts[k]);
         foreach (exp_q[i]) begin
            drive(i, 6'b000100, fn, zts[k]);
            n_checks++;
            if (act !== exp_q[i]) begin
               n_fail++;
               $display("FAIL beq zero=%b cyc%0d got %h expected %h", zts[k], i, act, exp_q[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_jump_illegal();
      logic [5:0] ops [4] = '{6'b000010, 6'b111111, 6'b000001, 6'b100000};
      foreach (ops[k]) begin
         logic [5:0] fn = 6'($urandom);
         build_seq(ops[k], fn, 1'b0);
         foreach (exp_q[i]) begin
            drive(i, ops[k], fn, 1'b0);
            n_checks++;
            if (act !== exp_q[i]) begin
               n_fail++;
               $display("FAIL jump_illegal op=%b cyc%0d got %h expected %h", ops[k], i, act, exp_q[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_addi();
      logic [5:0] fn = 6'($urandom);
      build_seq(6'b001000, fn, 1'b1);
      foreach (exp_q[i]) begin
         drive(i, 6'b001000, fn, 1'b1);
         n_checks++;
         if (act !== exp_q[i]) begin
            n_fail++;
            $display("FAIL addi cyc%0d got %h expected %h", i, act, exp_q[i]);
         end
         @(negedge clk);
      end
   endtask

   // Reset lands while a store is in MEMWR; the write must vanish at once and
   // the controller must restart cleanly from FETCH without completing it.
   task automatic test_reset_mid_write();
      logic [5:0] fn = 6'($urandom);
      ctl_t dec = '0;
      dec.pcWrite = 1'b1;
      build_seq(6'b101011, fn, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(i, 6'b101011, fn, 1'b0);
         n_checks++;
         if (act !== exp_q[i]) begin
            n_fail++;
            $display("FAIL reset_mid_pre cyc%0d got %h expected %h", i, act, exp_q[i]);
         end
         if (i < 3) @(negedge clk);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (act !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_drop got %h expected %h", act, ctl_t'('0));
      end
      repeat (3) begin
         @(negedge clk); #1;
         n_checks++;
         if (act !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_hold got %h expected %h", act, ctl_t'('0));
         end
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (act !== fetch_word()) begin
         n_fail++;
         $display("FAIL reset_mid_fetch got %h expected %h", act, fetch_word());
      end
      @(negedge clk); #1;
      n_checks++;
      if (act !== dec) begin
         n_fail++;
         $display("FAIL reset_mid_decode got %h expected %h", act, dec);
      end
      // finish the restarted instruction as a jump so the next test starts in FETCH
      opcode = 6'b000010;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int n = 0; n < 200; n++) begin
         logic [5:0] op = rand_opcode();
         logic [5:0] fn = rand_funct();
         logic zt = 1'($urandom);
         build_seq(op, fn, zt);
         foreach (exp_q[i]) begin
            drive(i, op, fn, zt);
            n_checks++;
            if (act !== exp_q[i]) begin
               n_fail++;
               $display("FAIL random#%0d op=%b fn=%b cyc%0d got %h expected %h",
                        n, op, fn, i, act, exp_q[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw_sw();
      test_rtype();
      test_beq();
      test_jump_illegal();
      test_addi();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
